// File: rtl/reset_sequencer.sv
// Staged reset-release controller: releases per-stage active-low resets from
// stage 0 upward, one every HOLD_CYCLES clocks, after power-on or a software request.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  busy_o,
  output logic                  seq_done_o
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam int IW = $clog2(NUM_STAGES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {RST, SEQ, DONE, SWH} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx, idx_d;
  logic [NUM_STAGES-1:0]   stage_d;
  logic                    busy_d;
  logic [1:0]              sync_q;
  logic                    rst_sync;
  logic                    rst_sync_rise;

  // Assertion is immediate through the async clear; deassertion takes two edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_sync = sync_q[1];
  // RST is left on the very edge rst_sync goes high, so stage 0 opens HOLD_CYCLES later.
  assign rst_sync_rise = sync_q[0] & ~rst_sync;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    stage_d = stage_rst_n_o;
    busy_d  = busy_o;
    case (state)
      RST: begin
        stage_d = '0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        if (rst_sync_rise) state_d = SEQ;
      end
      SEQ: begin
        busy_d = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          for (int k = 0; k < NUM_STAGES; k++)
            if (idx == IW'(k)) stage_d[k] = 1'b1;
          if (idx == IDX_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        if (sw_rst_req_i) begin
          state_d = SWH;
          stage_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SWH: begin
        busy_d  = 1'b1;
        stage_d = '0;
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SEQ;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RST;
      cnt           <= '0;
      idx           <= '0;
      stage_rst_n_o <= '0;
      busy_o        <= 1'b1;
      seq_done_o    <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      idx           <= idx_d;
      stage_rst_n_o <= stage_d;
      busy_o        <= busy_d;
      seq_done_o    <= ~busy_d;
    end
  end

endmodule
